fp_align_stage: RTL and testbench
=================================

Name: fp_align_stage

Overview:
- Pre-add alignment stage for the FP32 adder datapath; sits directly upstream of adder_24b.
- Accepts two IEEE-754 single operands and orders them by magnitude. Right-shifts the smaller significand by the exponent difference, with sticky collection.
- Forms the 25-bit adder operands (two's complement for effective subtraction), runs the REQ/ACK handshake with the adder, and presents the raw sum plus sign/exponent/sticky to the downstream normaliser.

Parameters:
- EXP_W, 8, exponent width; only the default is supported.
- FRAC_W, 23, stored fraction width; only the default is supported. Adder operand width ADD_W = FRAC_W+2 = 25.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-high
- IN_REQ  in  1  upstream request, level; operands valid while high
- IN_OPA  in  32  FP32 operand A
- IN_OPB  in  32  FP32 operand B
- IN_ACK  out  1  one-cycle pulse when the result is handed off downstream
- ADD_A  out  25  adder operand A (aligned larger significand)
- ADD_B  out  25  adder operand B (aligned smaller significand, negated if effective sub)
- ADD_REQ  out  1  request to adder
- ADD_Z  in  25  adder sum
- ADD_COUT  in  1  adder carry-out
- ADD_ACK  in  1  adder acknowledge (registered, one-cycle pulse)
- OUT_VALID  out  1  result valid; held until OUT_READY
- OUT_READY  in  1  downstream accepts
- OUT_SIGN  out  1  result sign
- OUT_EXP  out  8  exponent of the larger operand
- OUT_MANT  out  26  {carry, sum} unnormalised significand
- OUT_STICKY  out  1  OR of bits shifted out of the smaller significand
- OUT_EFF_SUB  out  1  effective subtraction flag
- OUT_SPECIAL  out  1  an operand had exponent 255; OUT_MANT is 0, and Inf/NaN resolution is handled downstream

Behaviour:
- Reset: RST high asynchronously forces state IDLE and drives every output to 0 (ADD_A, ADD_B, ADD_REQ, IN_ACK, OUT_*). The system asserts RST together with the adder's reset. A reset mid-handshake drops ADD_REQ immediately.
- All outputs are registered.
- States (enum AlignState):
  - IDLE: on IN_REQ=1, latch both operands and go to ALIGN.
  - ALIGN: one cycle.
    - Larger operand = greater {exp,frac} (31-bit compare); on a tie, A is larger. Sign = sign of the larger.
    - Significand = {hidden,frac}, where hidden = (exp!=0). Effective exponent = 1 when exp==0.
    - d = Ebig-Esmall. Smaller significand is shifted right by d; if d>=25 the result is 0. STICKY = OR of the shifted-out bits.
    - ADD_A = {0,mBig}. ADD_B = {0,mSm_aligned}, or its 25-bit two's complement when eff_sub = sA^sB.
    - Register the operands, set ADD_REQ=1, go to ADD.
    - If either exponent is 255: OUT_SPECIAL=1, skip the adder, go to OUTPUT.
  - ADD: hold ADD_REQ=1 and ADD_A/B stable. When ADD_ACK=1:
    - Capture OUT_MANT = eff_sub ? {0,ADD_Z} : {ADD_COUT,ADD_Z}.
    - Drop ADD_REQ, set OUT_VALID=1, go to OUTPUT.
    - Exact cancellation (OUT_MANT==0 with eff_sub) forces OUT_SIGN=0.
  - OUTPUT: hold all OUT_* stable. On OUT_READY=1: OUT_VALID<=0, IN_ACK<=1 for one cycle, go to RELEASE.
  - RELEASE: wait for IN_REQ=0, then go to IDLE. No re-accept while IN_REQ stays high.
- Latency: IN_REQ sampled at edge n; ADD_REQ high after n+1; adder ACK seen after n+2; OUT_VALID high after edge n+3. The special path gives OUT_VALID after n+2.
- Minimum gap between ADD_REQ falling and the next ADD_REQ is 3 cycles, which guarantees the adder has returned to Add_Compute.
- ADD_A/ADD_B/OUT_* keep their last values in IDLE. Only OUT_VALID qualifies the result.

Decomposition:
- Shared package fpu_pkg holds:
  - typedef enum AlignState {Align_Idle, Align_Align, Align_Add, Align_Output, Align_Release};
  - constants EXP_W, FRAC_W, ADD_W, EXP_SPECIAL=8'hFF.
- Sub-module fp_shift_sticky: a 24-bit right shifter with 8-bit amount. Outputs are the shifted value and sticky; it saturates to 0/|in for amount>=25.

Test Plan:
- 1.0+1.0 (3F800000, 3F800000) -> ADD_A=ADD_B=0x0800000. Model adder returns Z=0x1000000, COUT=0. Result: OUT_MANT=0x1000000, OUT_EXP=127, SIGN=0, EFF_SUB=0, STICKY=0, OUT_VALID 3 cycles after the IN_REQ sample.
- 1.5+(-1.0) (3FC00000, BF800000) -> ADD_A=0x0C00000, ADD_B=0x1800000. Adder gives COUT=1, Z=0x0400000. Result: OUT_MANT=0x0400000, SIGN=0, EFF_SUB=1.
- 1.0+(-2.0) (3F800000, C0000000) -> swap, d=1, ADD_A=0x0800000, ADD_B=0x1C00000. Result: OUT_MANT=0x0400000, SIGN=1, OUT_EXP=128.
- 2^24+1.0 (4B800000, 3F800000) -> d=24, ADD_B=0, STICKY=1, OUT_MANT=0x0800000, OUT_EXP=151. Also: 3F800000+BF800000 -> OUT_MANT=0, SIGN=0.
- Handshake: hold OUT_READY=0 for 5 cycles -> OUT_VALID and outputs stable, no IN_ACK. Then OUT_READY=1 -> single IN_ACK pulse. Keep IN_REQ high 4 more cycles -> no second ADD_REQ. Drop IN_REQ -> IDLE.
- Assert RST while in ADD (ADD_REQ=1) -> ADD_REQ, OUT_VALID, IN_ACK all 0 before the next edge. After release, a new 7F800000+3F800000 gives OUT_SPECIAL=1, with ADD_REQ never asserted.

Source files
------------

// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fpu_pkg
// Brief    : Shared FP32 datapath constants and alignment-stage state encoding.
// Revision : 1.0
// ============================================================================
package fpu_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int SIG_W  = FRAC_W + 1;
    localparam int ADD_W  = FRAC_W + 2;

    localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'hFF;

    typedef enum logic [2:0] {
        Align_Idle    = 3'd0,
        Align_Align   = 3'd1,
        Align_Add     = 3'd2,
        Align_Output  = 3'd3,
        Align_Release = 3'd4
    } AlignState;

endpackage : fpu_pkg
`default_nettype wire

// File: rtl/fp_shift_sticky.sv
`default_nettype none
// ============================================================================
// Module   : fp_shift_sticky
// Brief    : 24-bit right shifter with sticky (OR of all bits shifted out).
// Revision : 1.0
// ============================================================================
module fp_shift_sticky
    import fpu_pkg::*;
(
    input  logic [SIG_W-1:0] i_val,
    input  logic [7:0]       i_amt,
    output logic [SIG_W-1:0] o_val,
    output logic             o_sticky
);

    logic [SIG_W-1:0] w_mask;

    // Mask of the low bits that fall off for amounts below the saturation point
    assign w_mask = ~({SIG_W{1'b1}} << i_amt[4:0]);

    always_comb begin
        o_val    = '0;
        o_sticky = 1'b0;
        if (i_amt >= 8'd24) begin
            o_val    = '0;
            o_sticky = |i_val;
        end else begin
            o_val    = i_val >> i_amt[4:0];
            o_sticky = |(i_val & w_mask);
        end
    end

endmodule : fp_shift_sticky
`default_nettype wire

// File: rtl/fp_align_stage.sv
`default_nettype none
// ============================================================================
// Module   : fp_align_stage
// Brief    : FP32 pre-add alignment stage with REQ/ACK handshake to adder_24b.
// Revision : 1.0
// ============================================================================
module fp_align_stage
    import fpu_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 IN_REQ,
    input  logic [31:0]          IN_OPA,
    input  logic [31:0]          IN_OPB,
    output logic                 IN_ACK,
    output logic [ADD_W-1:0]     ADD_A,
    output logic [ADD_W-1:0]     ADD_B,
    output logic                 ADD_REQ,
    input  logic [ADD_W-1:0]     ADD_Z,
    input  logic                 ADD_COUT,
    input  logic                 ADD_ACK,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic                 OUT_SIGN,
    output logic [EXP_W-1:0]     OUT_EXP,
    output logic [ADD_W:0]       OUT_MANT,
    output logic                 OUT_STICKY,
    output logic                 OUT_EFF_SUB,
    output logic                 OUT_SPECIAL
);

    AlignState          r_state;
    AlignState          w_state_nxt;

    logic [31:0]        r_opa;
    logic [31:0]        r_opb;
    logic [ADD_W-1:0]   r_add_a;
    logic [ADD_W-1:0]   r_add_b;
    logic               r_add_req;
    logic               r_in_ack;
    logic               r_valid;
    logic               r_sign;
    logic [EXP_W-1:0]   r_exp;
    logic [ADD_W:0]     r_mant;
    logic               r_sticky;
    logic               r_eff_sub;
    logic               r_special;

    logic               w_a_big;
    logic [31:0]        w_big;
    logic [31:0]        w_sml;
    logic [EXP_W-1:0]   w_eb;
    logic [EXP_W-1:0]   w_es;
    logic [EXP_W-1:0]   w_ebe;
    logic [EXP_W-1:0]   w_ese;
    logic [EXP_W-1:0]   w_d;
    logic [SIG_W-1:0]   w_mb;
    logic [SIG_W-1:0]   w_ms;
    logic [SIG_W-1:0]   w_ms_al;
    logic               w_sticky;
    logic               w_eff_sub;
    logic               w_special;
    logic [ADD_W-1:0]   w_add_b_pos;
    logic [ADD_W-1:0]   w_add_b;
    logic [ADD_W:0]     w_sum;

    // Magnitude ordering on {exp,frac}; ties keep A as the larger operand
    assign w_a_big   = (r_opa[30:0] >= r_opb[30:0]);
    assign w_big     = w_a_big ? r_opa : r_opb;
    assign w_sml     = w_a_big ? r_opb : r_opa;
    assign w_eb      = w_big[30:23];
    assign w_es      = w_sml[30:23];
    assign w_mb      = {(w_eb != '0), w_big[22:0]};
    assign w_ms      = {(w_es != '0), w_sml[22:0]};
    assign w_ebe     = (w_eb == '0) ? 8'd1 : w_eb;
    assign w_ese     = (w_es == '0) ? 8'd1 : w_es;
    assign w_d       = w_ebe - w_ese;
    assign w_eff_sub = r_opa[31] ^ r_opb[31];
    assign w_special = (w_eb == EXP_SPECIAL) || (w_es == EXP_SPECIAL);

    fp_shift_sticky u_shift (
        .i_val    (w_ms),
        .i_amt    (w_d),
        .o_val    (w_ms_al),
        .o_sticky (w_sticky)
    );

    assign w_add_b_pos = {1'b0, w_ms_al};
    assign w_add_b     = w_eff_sub ? (-w_add_b_pos) : w_add_b_pos;
    // On subtraction the carry is the two's-complement artefact, not magnitude
    assign w_sum       = r_eff_sub ? {1'b0, ADD_Z} : {ADD_COUT, ADD_Z};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= Align_Idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            Align_Idle:    if (IN_REQ) w_state_nxt = Align_Align;
            Align_Align:   w_state_nxt = w_special ? Align_Output : Align_Add;
            Align_Add:     if (ADD_ACK) w_state_nxt = Align_Output;
            Align_Output:  if (r_valid && OUT_READY) w_state_nxt = Align_Release;
            Align_Release: if (!IN_REQ) w_state_nxt = Align_Idle;
            default:       w_state_nxt = Align_Idle;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_opa     <= '0;
            r_opb     <= '0;
            r_add_a   <= '0;
            r_add_b   <= '0;
            r_add_req <= 1'b0;
            r_in_ack  <= 1'b0;
            r_valid   <= 1'b0;
            r_sign    <= 1'b0;
            r_exp     <= '0;
            r_mant    <= '0;
            r_sticky  <= 1'b0;
            r_eff_sub <= 1'b0;
            r_special <= 1'b0;
        end else begin
            r_in_ack <= 1'b0;
            case (r_state)
                Align_Idle: begin
                    if (IN_REQ) begin
                        r_opa <= IN_OPA;
                        r_opb <= IN_OPB;
                    end
                end
                Align_Align: begin
                    r_add_a   <= {1'b0, w_mb};
                    r_add_b   <= w_add_b;
                    r_sign    <= w_big[31];
                    r_exp     <= w_eb;
                    r_sticky  <= w_sticky;
                    r_eff_sub <= w_eff_sub;
                    r_special <= w_special;
                    if (w_special) begin
                        r_mant <= '0;
                    end else begin
                        r_add_req <= 1'b1;
                    end
                end
                Align_Add: begin
                    if (ADD_ACK) begin
                        r_mant    <= w_sum;
                        r_add_req <= 1'b0;
                        r_valid   <= 1'b1;
                        if (r_eff_sub && (w_sum == '0)) begin
                            r_sign <= 1'b0;
                        end
                    end
                end
                Align_Output: begin
                    // Special path arrives with VALID low and raises it here
                    if (!r_valid) begin
                        r_valid <= 1'b1;
                    end else if (OUT_READY) begin
                        r_valid  <= 1'b0;
                        r_in_ack <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign IN_ACK      = r_in_ack;
    assign ADD_A       = r_add_a;
    assign ADD_B       = r_add_b;
    assign ADD_REQ     = r_add_req;
    assign OUT_VALID   = r_valid;
    assign OUT_SIGN    = r_sign;
    assign OUT_EXP     = r_exp;
    assign OUT_MANT    = r_mant;
    assign OUT_STICKY  = r_sticky;
    assign OUT_EFF_SUB = r_eff_sub;
    assign OUT_SPECIAL = r_special;

endmodule : fp_align_stage
`default_nettype wire

// File: tb/tb_fp_align_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_align_stage
// Brief    : Scoreboard bench for fp_align_stage with a registered adder model.
// Revision : 1.0
// ============================================================================
module tb_fp_align_stage;

    logic        CLK;
    logic        RST;
    logic        IN_REQ;
    logic [31:0] IN_OPA;
    logic [31:0] IN_OPB;
    logic        IN_ACK;
    logic [24:0] ADD_A;
    logic [24:0] ADD_B;
    logic        ADD_REQ;
    logic [24:0] ADD_Z;
    logic        ADD_COUT;
    logic        ADD_ACK;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic        OUT_SIGN;
    logic [7:0]  OUT_EXP;
    logic [25:0] OUT_MANT;
    logic        OUT_STICKY;
    logic        OUT_EFF_SUB;
    logic        OUT_SPECIAL;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [25:0] mant;
        logic        sticky;
        logic        eff_sub;
        logic        special;
        logic [24:0] add_a;
        logic [24:0] add_b;
    } exp_t;

    exp_t sb[$];

    fp_align_stage dut (
        .CLK         (CLK),
        .RST         (RST),
        .IN_REQ      (IN_REQ),
        .IN_OPA      (IN_OPA),
        .IN_OPB      (IN_OPB),
        .IN_ACK      (IN_ACK),
        .ADD_A       (ADD_A),
        .ADD_B       (ADD_B),
        .ADD_REQ     (ADD_REQ),
        .ADD_Z       (ADD_Z),
        .ADD_COUT    (ADD_COUT),
        .ADD_ACK     (ADD_ACK),
        .OUT_VALID   (OUT_VALID),
        .OUT_READY   (OUT_READY),
        .OUT_SIGN    (OUT_SIGN),
        .OUT_EXP     (OUT_EXP),
        .OUT_MANT    (OUT_MANT),
        .OUT_STICKY  (OUT_STICKY),
        .OUT_EFF_SUB (OUT_EFF_SUB),
        .OUT_SPECIAL (OUT_SPECIAL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Registered adder: acks one cycle after seeing a request, single pulse
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            ADD_ACK  <= 1'b0;
            ADD_Z    <= '0;
            ADD_COUT <= 1'b0;
        end else begin
            ADD_ACK <= ADD_REQ && !ADD_ACK;
            if (ADD_REQ && !ADD_ACK) begin
                {ADD_COUT, ADD_Z} <= {1'b0, ADD_A} + {1'b0, ADD_B};
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [31:0] big;
        logic [31:0] sml;
        int          eb;
        int          es;
        int          d;
        int unsigned mb;
        int unsigned ms;
        int unsigned al;
        if (b[30:0] > a[30:0]) begin
            big = b; sml = a;
        end else begin
            big = a; sml = b;
        end
        eb = int'(big[30:23]);
        es = int'(sml[30:23]);
        mb = ((eb != 0) ? 32'h0080_0000 : 32'h0) + {9'd0, big[22:0]};
        ms = ((es != 0) ? 32'h0080_0000 : 32'h0) + {9'd0, sml[22:0]};
        d  = ((eb == 0) ? 1 : eb) - ((es == 0) ? 1 : es);
        if (d >= 24) begin
            al       = 0;
            e.sticky = (ms != 0);
        end else begin
            al       = ms >> d;
            e.sticky = ((ms - (al << d)) != 0);
        end
        e.eff_sub = a[31] ^ b[31];
        e.special = (eb == 255) || (es == 255);
        e.add_a   = 25'(mb);
        e.add_b   = e.eff_sub ? 25'(32'd33554432 - al) : 25'(al);
        if (e.special)      e.mant = '0;
        else if (e.eff_sub) e.mant = 26'(mb - al);
        else                e.mant = 26'(mb + al);
        e.sign = (e.eff_sub && !e.special && (e.mant == '0)) ? 1'b0 : big[31];
        e.exp  = big[30:23];
        return e;
    endfunction

    task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input int hold);
        exp_t e;
        int   k;
        int   req_k;
        bit   seen_req;
        bit   seen_valid;
        sb.push_back(model(a, b));
        @(negedge CLK);
        IN_OPA = a;
        IN_OPB = b;
        IN_REQ = 1'b1;
        k = 0; req_k = 0; seen_req = 0; seen_valid = 0;
        while (!seen_valid && k < 20) begin
            @(negedge CLK);
            k++;
            if (ADD_REQ && !seen_req) begin
                seen_req = 1;
                req_k    = k;
                chk("add_a", 64'(ADD_A), 64'(sb[0].add_a));
                chk("add_b", 64'(ADD_B), 64'(sb[0].add_b));
            end
            if (OUT_VALID) seen_valid = 1;
        end
        e = sb.pop_front();
        if (!seen_valid) begin
            chk("valid_timeout", 64'(OUT_VALID), 64'd1);
            IN_REQ = 1'b0;
            repeat (4) @(negedge CLK);
            return;
        end
        if (e.special) begin
            chk("spec_latency", 64'(k), 64'd3);
            chk("spec_no_add_req", 64'(seen_req), 64'd0);
        end else begin
            chk("latency", 64'(k), 64'd4);
            chk("add_req_latency", 64'(req_k), 64'd2);
        end
        chk("sign",    64'(OUT_SIGN),    64'(e.sign));
        chk("exp",     64'(OUT_EXP),     64'(e.exp));
        chk("mant",    64'(OUT_MANT),    64'(e.mant));
        chk("sticky",  64'(OUT_STICKY),  64'(e.sticky));
        chk("eff_sub", 64'(OUT_EFF_SUB), 64'(e.eff_sub));
        chk("special", 64'(OUT_SPECIAL), 64'(e.special));
        repeat (hold) begin
            @(negedge CLK);
            chk("hold_stable",
                64'({OUT_VALID, IN_ACK, OUT_SIGN, OUT_EXP, OUT_MANT, OUT_STICKY, OUT_EFF_SUB, OUT_SPECIAL}),
                64'({1'b1, 1'b0, e.sign, e.exp, e.mant, e.sticky, e.eff_sub, e.special}));
        end
        OUT_READY = 1'b1;
        @(negedge CLK);
        OUT_READY = 1'b0;
        chk("in_ack_pulse", 64'(IN_ACK), 64'd1);
        chk("valid_drop", 64'(OUT_VALID), 64'd0);
        repeat (4) begin
            @(negedge CLK);
            chk("no_reaccept", 64'({ADD_REQ, OUT_VALID, IN_ACK}), 64'd0);
        end
        IN_REQ = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        RST       = 1'b1;
        IN_REQ    = 1'b0;
        IN_OPA    = '0;
        IN_OPB    = '0;
        OUT_READY = 1'b0;
        #12;
        chk("reset_outputs",
            64'({IN_ACK, ADD_REQ, OUT_VALID, OUT_SIGN, OUT_EXP, OUT_STICKY, OUT_EFF_SUB, OUT_SPECIAL}), 64'd0);
        chk("reset_add_ab", 64'({ADD_A, ADD_B}), 64'd0);
        chk("reset_mant", 64'(OUT_MANT), 64'd0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        run_txn(32'h3F80_0000, 32'h3F80_0000, 0);   // 1.0 + 1.0
        run_txn(32'h3FC0_0000, 32'hBF80_0000, 0);   // 1.5 - 1.0
        run_txn(32'h3F80_0000, 32'hC000_0000, 0);   // 1.0 - 2.0, swap
        run_txn(32'h4B80_0000, 32'h3F80_0000, 0);   // d = 24
        run_txn(32'h4C00_0000, 32'h3F80_0000, 0);   // d = 25
        run_txn(32'h3F80_0000, 32'hBF80_0000, 0);   // exact cancellation
        run_txn(32'h0040_0000, 32'h0020_0000, 0);   // denormals
        run_txn(32'h4040_0001, 32'h3F80_0003, 5);   // handshake hold

        // Reset while the adder request is outstanding
        @(negedge CLK);
        IN_OPA = 32'h3F80_0000;
        IN_OPB = 32'h4000_0000;
        IN_REQ = 1'b1;
        repeat (2) @(negedge CLK);
        chk("rst_pre_add_req", 64'(ADD_REQ), 64'd1);
        #1 RST = 1'b1;
        #1;
        chk("rst_add_req", 64'(ADD_REQ), 64'd0);
        chk("rst_valid", 64'(OUT_VALID), 64'd0);
        chk("rst_in_ack", 64'(IN_ACK), 64'd0);
        chk("rst_add_a", 64'(ADD_A), 64'd0);
        IN_REQ = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        run_txn(32'h7F80_0000, 32'h3F80_0000, 0);   // Inf + 1.0

        for (int i = 0; i < 6; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = {1'($urandom), 8'($urandom_range(160, 100)), 23'($urandom)};
            rb = {1'($urandom), 8'($urandom_range(160, 100)), 23'($urandom)};
            run_txn(ra, rb, int'($urandom_range(2, 0)));
        end

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_fp_align_stage
`default_nettype wire
